can_crc_unit: RTL and testbench
===============================

# can_crc_unit

Multi-mode, bit-serial CAN CRC engine for classical CAN (CRC-15) and CAN FD (CRC-17/CRC-21). It sits beside the bit-destuffer in the receive path and the bit-stuffer in the transmit path. It accumulates the CRC over the frame bits, flags a zero remainder for receive-side checking, and serialises the computed CRC MSB-first for transmission.

## Interface
- `MAXBITS`, 21 — register width; must be ≥ the widest mode.
- `POLY15`, 'h4599 — CRC-15 polynomial, without the x^15 term.
- `POLY17`, 'h1685B — CRC-17 polynomial, without the x^17 term.
- `POLY21`, 'h102899 — CRC-21 polynomial, without the x^21 term.
- `clk` in 1 — clock.
- `rst` in 1 — synchronous, active-high reset.
- `start` in 1 — load the init value, latch `mode`, enter ACCUM.
- `mode` in 2 — 0 = CRC-15, 1 = CRC-17, 2 = CRC-21, 3 = treated as CRC-15. Sampled only on `start`.
- `bit_valid` in 1 — one bit-time strobe: consumes `din` in ACCUM and emits one CRC bit in SHIFT.
- `din` in 1 — serial frame bit.
- `shift_out` in 1 — in ACCUM, begin serialising the CRC.
- `crc` out MAXBITS — current register; bits ≥ active width always 0.
- `crc_zero` out 1 — registered, high when `crc == 0`.
- `tx_bit` out 1 — `crc[W-1]`, combinational from the register.
- `tx_last` out 1 — high while the final CRC bit is presented in SHIFT.
- `busy` out 1 — high when the state is not IDLE.

## Operation
- Active width W: 15, 17 or 21 from the latched mode. Polynomial P and init I are selected per mode. Init values:
  - CRC-15: 0
  - CRC-17: 'h10000
  - CRC-21: 'h100000
- Per-bit step: `nxt = din ^ crc[W-1]`; `crc <= ({crc[W-2:0],1'b0} ^ (nxt ? P : 0))`, masked to W bits. Feeding data followed by its own CRC leaves `crc == 0`.
- States:
  - IDLE: `bit_valid`, `din` and `shift_out` are ignored.
  - ACCUM: each `bit_valid` applies one step. `shift_out` moves to SHIFT and loads the bit counter with W-1.
  - SHIFT: each `bit_valid` shifts `crc` left by one with 0 fill and decrements the counter; `din` is ignored. `bit_valid` with counter = 0 returns to IDLE.
- `start` is honoured in every state, including mid-SHIFT: it reloads I, relatches mode and enters ACCUM.
- Priority: `rst` > `start` > `shift_out` > `bit_valid`. `start` and `bit_valid` in the same cycle: the bit is dropped. `shift_out` and `bit_valid` in the same cycle in ACCUM: enter SHIFT without consuming `din`.
- `crc_zero` is updated in every cycle `crc` changes, from the next value.
- Reset values: state IDLE, `crc` 0, `crc_zero` 1, counter 0, latched mode CRC-15, `busy` 0, `tx_last` 0.

## Timing
- `start` at cycle t: `crc = I`, `busy = 1` and `crc_zero = (I == 0)` at t+1.
- `bit_valid` at t: updated `crc` and `crc_zero` at t+1 (1-cycle latency, one bit per cycle maximum).
- `tx_bit` is valid in the cycle SHIFT is entered. It advances at t+1 after each `bit_valid` at t.
- `tx_last` is high while counter = 0 in SHIFT. It drops and `busy` drops the cycle after the consuming `bit_valid`.
- Reset mid-operation: all outputs return to their reset values at the next edge; no partial shift survives.

## Structure
- Package `can_crc_pkg` holds:
  - the mode enum and state enum (IDLE/ACCUM/SHIFT);
  - per-mode width constants (15/17/21);
  - default polynomial and init constants;
  - a width/poly/init lookup function.
- Sub-module `can_crc_step`: purely combinational single-bit LFSR step (`crc`, `din`, `P`, `W` → next `crc`). The top level holds the FSM, counter and registers.

## Test plan
- CRC-15: `start`, then `din = 1` for one bit → `crc = 'h4599`. Then feed the 15 bits of 'h4599 MSB-first → `crc = 0`, `crc_zero = 1`.
- CRC-17: `start`, then `din = 0` for one bit → `crc` = 'h10000 after start, then 'h1685B. `crc_zero` stays 0.
- Mode 3: behaves exactly as mode 0; `crc[20:15]` stays 0 throughout.
- TX serialise: CRC-15 with `crc = 'h4599`, `shift_out`, then 15 `bit_valid` → `tx_bit` sequence 100010110011001. `tx_last` high only on the 15th bit, then IDLE with `busy = 0`.
- Priority: `start` with `bit_valid`/`din = 1` in ACCUM → `crc = I`, bit dropped. `shift_out` with `bit_valid` → SHIFT, `crc` unchanged.
- `rst` asserted on the 5th SHIFT bit → next cycle `crc = 0`, `crc_zero = 1`, `busy = 0`, `tx_last = 0`. Subsequent `bit_valid` is ignored.

Source files
------------

// File: rtl/can_crc_pkg.sv
// Shared types and per-mode constants for the CAN CRC engine.
package can_crc_pkg;

    localparam int unsigned CRC_MAXW = 21;

    localparam logic [4:0] W_CRC15 = 5'd15;
    localparam logic [4:0] W_CRC17 = 5'd17;
    localparam logic [4:0] W_CRC21 = 5'd21;

    localparam logic [CRC_MAXW-1:0] DEF_POLY15 = 21'h004599;
    localparam logic [CRC_MAXW-1:0] DEF_POLY17 = 21'h01685B;
    localparam logic [CRC_MAXW-1:0] DEF_POLY21 = 21'h102899;

    localparam logic [CRC_MAXW-1:0] INIT15 = 21'h000000;
    localparam logic [CRC_MAXW-1:0] INIT17 = 21'h010000;
    localparam logic [CRC_MAXW-1:0] INIT21 = 21'h100000;

    typedef enum logic [1:0] {
        MODE_CRC15 = 2'd0,
        MODE_CRC17 = 2'd1,
        MODE_CRC21 = 2'd2
    } crc_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_SHIFT = 2'd2
    } state_e;

    typedef struct packed {
        logic [4:0]          width;
        logic [CRC_MAXW-1:0] poly;
        logic [CRC_MAXW-1:0] init;
    } crc_cfg_t;

    // Encoding 3 is not a distinct mode; it folds onto CRC-15.
    function automatic crc_mode_e mode_decode(input logic [1:0] m);
        case (m)
            2'd1:    return MODE_CRC17;
            2'd2:    return MODE_CRC21;
            default: return MODE_CRC15;
        endcase
    endfunction

    function automatic crc_cfg_t crc_lookup(input crc_mode_e m,
                                            input logic [CRC_MAXW-1:0] p15,
                                            input logic [CRC_MAXW-1:0] p17,
                                            input logic [CRC_MAXW-1:0] p21);
        crc_cfg_t c;
        case (m)
            MODE_CRC17: c = '{width: W_CRC17, poly: p17, init: INIT17};
            MODE_CRC21: c = '{width: W_CRC21, poly: p21, init: INIT21};
            default:    c = '{width: W_CRC15, poly: p15, init: INIT15};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/can_crc_unit_if.sv
// Control/data bundle between the bit (de)stuffer and the CRC engine.
interface can_crc_unit_if #(
    parameter int unsigned MAXBITS = 21
);
    logic               start;
    logic [1:0]         mode;
    logic               bit_valid;
    logic               din;
    logic               shift_out;
    logic [MAXBITS-1:0] crc;
    logic               crc_zero;
    logic               tx_bit;
    logic               tx_last;
    logic               busy;

    modport master (
        output start, mode, bit_valid, din, shift_out,
        input  crc, crc_zero, tx_bit, tx_last, busy
    );

    modport slave (
        input  start, mode, bit_valid, din, shift_out,
        output crc, crc_zero, tx_bit, tx_last, busy
    );
endinterface

// File: rtl/can_crc_step.sv
// Single-bit LFSR step of a W-bit CRC; result masked to the active width.
module can_crc_step #(
    parameter int unsigned MAXBITS = 21
) (
    input  logic [MAXBITS-1:0] crc_i,
    input  logic               din_i,
    input  logic [MAXBITS-1:0] poly_i,
    input  logic [4:0]         width_i,
    output logic [MAXBITS-1:0] crc_o
);
    logic [MAXBITS-1:0] mask;
    logic               nxt;

    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < MAXBITS; i++) begin
            mask[i] = (i < 32'(width_i));
        end
        nxt   = din_i ^ crc_i[width_i - 5'd1];
        crc_o = ({crc_i[MAXBITS-2:0], 1'b0} ^ (nxt ? poly_i : '0)) & mask;
    end
endmodule

// File: rtl/can_crc_unit.sv
// Bit-serial CRC-15/17/21 engine: accumulate frame bits, then shift CRC out MSB-first.
module can_crc_unit
    import can_crc_pkg::*;
#(
    parameter int unsigned         MAXBITS = CRC_MAXW,
    parameter logic [CRC_MAXW-1:0] POLY15  = DEF_POLY15,
    parameter logic [CRC_MAXW-1:0] POLY17  = DEF_POLY17,
    parameter logic [CRC_MAXW-1:0] POLY21  = DEF_POLY21
) (
    input  logic            clk,
    input  logic            rst,
    can_crc_unit_if.slave   bus
);
    state_e             state_q, state_d;
    crc_mode_e          mode_q, mode_d;
    logic [MAXBITS-1:0] crc_q, crc_d, step_crc;
    logic               zero_q, zero_d;
    logic [4:0]         cnt_q, cnt_d;
    logic               tx_bit, step_din;
    crc_cfg_t           cur_cfg, new_cfg;
    logic               cfg_unused;

    assign cur_cfg    = crc_lookup(mode_q, POLY15, POLY17, POLY21);
    assign new_cfg    = crc_lookup(mode_decode(bus.mode), POLY15, POLY17, POLY21);
    assign cfg_unused = ^{cur_cfg.init, new_cfg.width, new_cfg.poly};

    assign tx_bit = crc_q[cur_cfg.width - 5'd1];
    // Feeding the register's own MSB back cancels the feedback term, so the
    // same step yields the plain zero-fill shift needed in SHIFT.
    assign step_din = (state_q == ST_SHIFT) ? tx_bit : bus.din;

    can_crc_step #(.MAXBITS(MAXBITS)) u_step (
        .crc_i   (crc_q),
        .din_i   (step_din),
        .poly_i  (MAXBITS'(cur_cfg.poly)),
        .width_i (cur_cfg.width),
        .crc_o   (step_crc)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        crc_d   = crc_q;
        cnt_d   = cnt_q;
        if (bus.start) begin
            state_d = ST_ACCUM;
            mode_d  = mode_decode(bus.mode);
            crc_d   = MAXBITS'(new_cfg.init);
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (bus.shift_out) begin
                        state_d = ST_SHIFT;
                        cnt_d   = cur_cfg.width - 5'd1;
                    end else if (bus.bit_valid) begin
                        crc_d = step_crc;
                    end
                end
                ST_SHIFT: begin
                    if (bus.bit_valid) begin
                        crc_d = step_crc;
                        if (cnt_q == '0) begin
                            state_d = ST_IDLE;
                        end else begin
                            cnt_d = cnt_q - 5'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
        zero_d = (crc_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_CRC15;
            crc_q   <= '0;
            zero_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            crc_q   <= crc_d;
            zero_q  <= zero_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.crc      = crc_q;
    assign bus.crc_zero = zero_q;
    assign bus.tx_bit   = tx_bit;
    assign bus.tx_last  = (state_q == ST_SHIFT) && (cnt_q == '0);
    assign bus.busy     = (state_q != ST_IDLE);
endmodule

// File: tb/tb_can_crc_unit.sv
// Self-checking bench for can_crc_unit: directed cases plus randomized frames vs. a reference model.
module tb_can_crc_unit;
    logic clk;
    logic rst;
    int   tests;
    int   failed;

    can_crc_unit_if #(.MAXBITS(21)) bus ();

    can_crc_unit #(.MAXBITS(21)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: CRC defined as the per-bit polynomial division rule.
    function automatic int unsigned m_width(input int m);
        return (m == 1) ? 17 : (m == 2) ? 21 : 15;
    endfunction

    function automatic int unsigned m_poly(input int m);
        return (m == 1) ? 32'h1685B : (m == 2) ? 32'h102899 : 32'h4599;
    endfunction

    function automatic int unsigned m_init(input int m);
        return (m == 1) ? 32'h10000 : (m == 2) ? 32'h100000 : 32'h0;
    endfunction

    function automatic int unsigned m_step(input int unsigned c, input int unsigned d, input int m);
        int unsigned w, top, r;
        w   = m_width(m);
        top = (c >> (w - 1)) & 1;
        r   = (c << 1) & ((32'd1 << w) - 1);
        if ((top ^ d) != 0) r = r ^ m_poly(m);
        return r;
    endfunction

    task automatic drive(input logic st, input logic [1:0] md, input logic bv,
                         input logic d, input logic so, input logic r);
        bus.start     = st;
        bus.mode      = md;
        bus.bit_valid = bv;
        bus.din       = d;
        bus.shift_out = so;
        rst           = r;
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.bit_valid = 1'b0;
        bus.din       = 1'b0;
        bus.shift_out = 1'b0;
        rst           = 1'b0;
    endtask

    task automatic test_reset;
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tests++;
        if (bus.crc !== 21'h0) begin failed++; $display("FAIL reset_crc: got %h exp 0", bus.crc); end
        tests++;
        if (bus.crc_zero !== 1'b1) begin failed++; $display("FAIL reset_zero: got %b exp 1", bus.crc_zero); end
        tests++;
        if (bus.busy !== 1'b0 || bus.tx_last !== 1'b0 || bus.tx_bit !== 1'b0) begin
            failed++; $display("FAIL reset_flags: busy=%b tx_last=%b tx_bit=%b exp 0 0 0", bus.busy, bus.tx_last, bus.tx_bit);
        end
        // Idle ignores bit strobes and shift requests.
        drive(1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        tests++;
        if (bus.crc !== 21'h0 || bus.busy !== 1'b0) begin
            failed++; $display("FAIL idle_ignore: crc=%h busy=%b exp 0 0", bus.crc, bus.busy);
        end
    endtask

    task automatic test_crc15;
        logic [14:0] v;
        drive(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++;
        if (bus.crc !== 21'h0 || bus.crc_zero !== 1'b1 || bus.busy !== 1'b1) begin
            failed++; $display("FAIL crc15_start: crc=%h zero=%b busy=%b exp 0 1 1", bus.crc, bus.crc_zero, bus.busy);
        end
        drive(1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        tests++;
        if (bus.crc !== 21'h4599 || bus.crc_zero !== 1'b0) begin
            failed++; $display("FAIL crc15_one: crc=%h zero=%b exp 004599 0", bus.crc, bus.crc_zero);
        end
        v = 15'h4599;
        for (int k = 14; k >= 0; k--) drive(1'b0, 2'd0, 1'b1, v[k], 1'b0, 1'b0);
        tests++;
        if (bus.crc !== 21'h0 || bus.crc_zero !== 1'b1) begin
            failed++; $display("FAIL crc15_residue: crc=%h zero=%b exp 0 1", bus.crc, bus.crc_zero);
        end
    endtask

    task automatic test_crc17;
        drive(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++;
        if (bus.crc !== 21'h10000 || bus.crc_zero !== 1'b0) begin
            failed++; $display("FAIL crc17_init: crc=%h zero=%b exp 010000 0", bus.crc, bus.crc_zero);
        end
        drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tests++;
        if (bus.crc !== 21'h1685B || bus.crc_zero !== 1'b0) begin
            failed++; $display("FAIL crc17_zero_bit: crc=%h zero=%b exp 01685b 0", bus.crc, bus.crc_zero);
        end
        drive(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++;
        if (bus.crc !== 21'h100000) begin failed++; $display("FAIL crc21_init: got %h exp 100000", bus.crc); end
    endtask

    task automatic test_mode3;
        int unsigned e;
        logic [20:0] ev;
        logic        d;
        int          bad;
        bad = 0;
        drive(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        e = m_init(0);
        for (int k = 0; k < 30; k++) begin
            d = 1'($urandom_range(0, 1));
            drive(1'b0, 2'd3, 1'b1, d, 1'b0, 1'b0);
            e  = m_step(e, 32'(d), 0);
            ev = 21'(e);
            if (bus.crc !== ev || bus.crc[20:15] !== 6'h0) bad++;
        end
        tests++;
        if (bad != 0) begin failed++; $display("FAIL mode3_as_crc15: %0d bit errors exp 0, last crc=%h", bad, bus.crc); end
    endtask

    task automatic test_tx_serialise;
        logic [14:0] seq;
        seq = 15'b100010110011001;
        drive(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 15; k++) begin
            tests++;
            if (bus.tx_bit !== seq[14-k] || bus.tx_last !== (k == 14) || bus.busy !== 1'b1) begin
                failed++;
                $display("FAIL tx_bit%0d: tx_bit=%b tx_last=%b busy=%b exp %b %b 1",
                         k, bus.tx_bit, bus.tx_last, bus.busy, seq[14-k], (k == 14));
            end
            drive(1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        tests++;
        if (bus.busy !== 1'b0 || bus.tx_last !== 1'b0 || bus.crc !== 21'h0) begin
            failed++; $display("FAIL tx_done: busy=%b tx_last=%b crc=%h exp 0 0 0", bus.busy, bus.tx_last, bus.crc);
        end
    endtask

    task automatic test_priority;
        drive(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        tests++;
        if (bus.crc !== 21'h0 || bus.busy !== 1'b1) begin
            failed++; $display("FAIL prio_start_bit: crc=%h busy=%b exp 0 1", bus.crc, bus.busy);
        end
        drive(1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        tests++;
        if (bus.crc !== 21'h4599 || bus.tx_bit !== 1'b1 || bus.busy !== 1'b1 || bus.tx_last !== 1'b0) begin
            failed++; $display("FAIL prio_shift_bit: crc=%h tx_bit=%b busy=%b tx_last=%b exp 004599 1 1 0",
                               bus.crc, bus.tx_bit, bus.busy, bus.tx_last);
        end
        drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        tests++;
        if (bus.crc !== 21'h100000 || bus.busy !== 1'b1 || bus.tx_last !== 1'b0) begin
            failed++; $display("FAIL start_mid_shift: crc=%h busy=%b tx_last=%b exp 100000 1 0", bus.crc, bus.busy, bus.tx_last);
        end
    endtask

    task automatic test_reset_mid_shift;
        drive(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        tests++;
        if (bus.crc !== 21'h0 || bus.crc_zero !== 1'b1 || bus.busy !== 1'b0 || bus.tx_last !== 1'b0) begin
            failed++; $display("FAIL rst_mid_shift: crc=%h zero=%b busy=%b tx_last=%b exp 0 1 0 0",
                               bus.crc, bus.crc_zero, bus.busy, bus.tx_last);
        end
        drive(1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        tests++;
        if (bus.crc !== 21'h0 || bus.busy !== 1'b0) begin
            failed++; $display("FAIL rst_then_bit: crc=%h busy=%b exp 0 0", bus.crc, bus.busy);
        end
    endtask

    task automatic test_random;
        int          m, n, w;
        int unsigned e, c;
        logic [20:0] ev;
        logic        d, eb;
        for (int it = 0; it < 24; it++) begin
            m = $urandom_range(0, 3);
            w = m_width(m % 3 == 0 && m == 3 ? 0 : m);
            if (m == 3) w = 15;
            drive(1'b1, 2'(m), 1'b0, 1'b0, 1'b0, 1'b0);
            e = m_init((m == 3) ? 0 : m);
            n = $urandom_range(1, 40);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 3) == 0) drive(1'b0, 2'(m), 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
                d = 1'($urandom_range(0, 1));
                drive(1'b0, 2'(m), 1'b1, d, 1'b0, 1'b0);
                e  = m_step(e, 32'(d), (m == 3) ? 0 : m);
                ev = 21'(e);
                tests++;
                if (bus.crc !== ev || bus.crc_zero !== (e == 0)) begin
                    failed++; $display("FAIL rand_accum it%0d bit%0d: crc=%h zero=%b exp %h %b",
                                       it, k, bus.crc, bus.crc_zero, ev, (e == 0));
                end
            end
            c = e;
            if (it % 2 == 0) begin
                for (int k = w - 1; k >= 0; k--) drive(1'b0, 2'(m), 1'b1, 1'((c >> k) & 1), 1'b0, 1'b0);
                tests++;
                if (bus.crc !== 21'h0 || bus.crc_zero !== 1'b1) begin
                    failed++; $display("FAIL rand_residue it%0d: crc=%h zero=%b exp 0 1", it, bus.crc, bus.crc_zero);
                end
            end else begin
                drive(1'b0, 2'(m), 1'b0, 1'b0, 1'b1, 1'b0);
                for (int k = w - 1; k >= 0; k--) begin
                    eb = 1'((c >> k) & 1);
                    tests++;
                    if (bus.tx_bit !== eb || bus.tx_last !== (k == 0)) begin
                        failed++; $display("FAIL rand_tx it%0d pos%0d: tx_bit=%b tx_last=%b exp %b %b",
                                           it, k, bus.tx_bit, bus.tx_last, eb, (k == 0));
                    end
                    if ($urandom_range(0, 3) == 0) drive(1'b0, 2'(m), 1'b0, 1'b1, 1'b0, 1'b0);
                    drive(1'b0, 2'(m), 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
                end
                tests++;
                if (bus.busy !== 1'b0 || bus.crc !== 21'h0) begin
                    failed++; $display("FAIL rand_tx_end it%0d: busy=%b crc=%h exp 0 0", it, bus.busy, bus.crc);
                end
            end
        end
    endtask

    initial begin
        tests         = 0;
        failed        = 0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.mode      = 2'd0;
        bus.bit_valid = 1'b0;
        bus.din       = 1'b0;
        bus.shift_out = 1'b0;
        test_reset;
        test_crc15;
        test_crc17;
        test_mode3;
        test_tx_serialise;
        test_priority;
        test_reset_mid_shift;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
